// File: rtl/idct8_serial.sv
// 8-point serial 1-D inverse DCT: loads X[0..7], runs 64 MACs on one multiplier, streams x[0..7].
// Optional output saturation and sat_flag port are enabled by defining IDCT_SAT_EN.
module idct8_serial #(
  parameter int DW = 12,
  parameter int CW = 12,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic                 busy,
`ifdef IDCT_SAT_EN
  output logic                 sat_flag,
`endif
  output logic [1:0]           state_dbg
);

  // Handshake: a transfer happens on the rising edge where valid && ready are both high;
  // the source holds data/last stable while valid is high and ready is low.

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [CW-1:0] C1 = CW'(2008);
  localparam logic [CW-1:0] C2 = CW'(1892);
  localparam logic [CW-1:0] C3 = CW'(1702);
  localparam logic [CW-1:0] C4 = CW'(1448);
  localparam logic [CW-1:0] C5 = CW'(1137);
  localparam logic [CW-1:0] C6 = CW'(783);
  localparam logic [CW-1:0] C7 = CW'(399);

  logic [1:0]           state;
  logic [2:0]           kcnt;
  logic [2:0]           ncnt;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] coef   [8];
  logic [DW-1:0]        result [8];

  logic [4:0]           m5, mf, idx;
  logic                 neg;
  logic [CW-1:0]        mag;
  logic signed [CW:0]   wpos, wgt;
  logic signed [DW-1:0] coef_sel;
  logic signed [AW-1:0] prod, acc_base, acc_next;
  logic [DW-1:0]        res_fmt;

  // Cosine index m = (2n+1)k mod 32, folded onto c1..c7 with a sign.
  always_comb begin
    m5   = 5'({ncnt, 1'b1}) * 5'(kcnt);
    mf   = (m5 > 5'd16) ? 5'(6'd32 - {1'b0, m5}) : m5;
    neg  = (mf > 5'd8);
    idx  = neg ? (5'd16 - mf) : mf;
    case (idx)
      5'd1:    mag = C1;
      5'd2:    mag = C2;
      5'd3:    mag = C3;
      5'd4:    mag = C4;
      5'd5:    mag = C5;
      5'd6:    mag = C6;
      5'd7:    mag = C7;
      default: mag = '0;
    endcase
    if (kcnt == 3'd0) begin
      mag = C4;
      neg = 1'b0;
    end
    wpos = $signed({1'b0, mag});
    wgt  = neg ? -wpos : wpos;
  end

  always_comb begin
    coef_sel = coef[kcnt];
    prod     = AW'(coef_sel) * AW'(wgt);
    acc_base = (kcnt == 3'd0) ? '0 : acc;
    acc_next = acc_base + prod;
  end

`ifdef IDCT_SAT_EN
  localparam int SMAX = 2 ** (DW - 1) - 1;
  localparam int SMIN = -(2 ** (DW - 1));
  logic signed [AW-1:0] shifted;
  logic                 res_sat;
  logic [7:0]           sat_buf;

  always_comb begin
    shifted = acc_next >>> CW;
    res_sat = 1'b1;
    if (shifted > AW'(SMAX))      res_fmt = DW'(SMAX);
    else if (shifted < AW'(SMIN)) res_fmt = DW'(SMIN);
    else begin
      res_fmt = shifted[DW-1:0];
      res_sat = 1'b0;
    end
  end
`else
  always_comb res_fmt = acc_next[DW+CW-1:CW];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      kcnt  <= '0;
      ncnt  <= '0;
      acc   <= '0;
      for (int i = 0; i < 8; i++) begin
        coef[i]   <= '0;
        result[i] <= '0;
      end
`ifdef IDCT_SAT_EN
      sat_buf <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            coef[kcnt] <= in_data;
            kcnt       <= kcnt + 3'd1;
            if (kcnt == 3'd7) state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          kcnt <= kcnt + 3'd1;
          if (kcnt == 3'd7) begin
            result[ncnt] <= res_fmt;
`ifdef IDCT_SAT_EN
            sat_buf[ncnt] <= res_sat;
`endif
            ncnt <= ncnt + 3'd1;
            if (ncnt == 3'd7) state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            ncnt <= ncnt + 3'd1;
            if (ncnt == 3'd7) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Outputs are forced to their reset values during the reset cycle itself.
  always_comb begin
    in_ready  = !rst && (state == LOAD);
    out_valid = !rst && (state == OUT);
    out_data  = out_valid ? result[ncnt] : '0;
    out_last  = out_valid && (ncnt == 3'd7);
    busy      = !rst && ((state == CALC) || (state == OUT));
    state_dbg = state;
  end

`ifdef IDCT_SAT_EN
  always_comb sat_flag = out_valid && sat_buf[ncnt];
`endif

endmodule

// File: tb/tb_idct8_serial.sv
// Scoreboard bench for idct8_serial: a cosine-formula reference model feeds an expected
// queue; a negedge monitor pops and compares each accepted output sample.
module tb_idct8_serial;

  localparam int DW = 12;
`ifdef IDCT_SAT_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_data;
  logic                 out_last;
  logic                 busy;
  logic [1:0]           state_dbg;
`ifdef IDCT_SAT_EN
  logic                 sat_flag;
`endif

  idct8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
`ifdef IDCT_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_pass = 0;
  int  n_total = 0;
  logic [EW-1:0] exp_q[$];
  int  blk[8];
  int  accept_cyc = 0;
  bit  wait_first = 0;
  bit  push_en = 1;
  bit  rdy_rand = 0;
  bit  hold = 0;
  int  out_idx = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int weight(input int n, input int k);
    real a, mag;
    if (k == 0) return 1448;
    a   = $cos(3.14159265358979323846 * real'((2 * n + 1) * k) / 16.0);
    mag = $floor(2048.0 * ((a < 0.0) ? -a : a));
    return (a < 0.0) ? -int'(mag) : int'(mag);
  endfunction

  task automatic model_push();
    for (int n = 0; n < 8; n++) begin
      longint s = 0;
      longint q;
      int     v;
      bit     clip = 0;
      for (int k = 0; k < 8; k++) s += longint'(blk[k]) * longint'(weight(n, k));
      q = s >>> 12;
`ifdef IDCT_SAT_EN
      if (q > 2047) begin v = 2047; clip = 1; end
      else if (q < -2048) begin v = -2048; clip = 1; end
      else v = int'(q);
      exp_q.push_back({clip, DW'(v)});
`else
      v = int'(((q % 4096) + 4096) % 4096);
      if (v >= 2048) v -= 4096;
      if (clip) v = 0;
      exp_q.push_back(DW'(v));
`endif
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_block(input bit rnd);
    int k = 0;
    int g = 0;
    if (push_en) model_push();
    while (k < 8) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = DW'(blk[k]);
      @(negedge clk);
      if (in_valid && in_ready) begin
        k++;
        if (k == 8) begin
          accept_cyc = cyc;
          wait_first = push_en;
        end
      end
      @(posedge clk); #1;
      g++;
      if (g > 2000) begin
        chk("load_timeout", k, 8);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_block();
    for (int k = 0; k < 8; k++) blk[k] = $urandom_range(0, 4095) - 2048;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!hold) out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (wait_first) begin
        chk("latency", cyc - accept_cyc, 65);
        wait_first = 0;
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk($sformatf("x[%0d]", out_idx), int'($signed(out_data)), int'($signed(e[DW-1:0])));
          chk($sformatf("last[%0d]", out_idx), int'(out_last), int'(out_idx == 7));
`ifdef IDCT_SAT_EN
          chk($sformatf("sat[%0d]", out_idx), int'(sat_flag), int'(e[EW-1]));
`endif
          out_idx = (out_idx + 1) % 8;
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("load_in_ready", int'(in_ready), 1);
    chk("load_state", int'(state_dbg), 0);
    @(posedge clk); #1;

    // DC only
    blk = '{1000, 0, 0, 0, 0, 0, 0, 0};
    load_block(0);
    @(negedge clk);
    chk("calc_busy", int'(busy), 1);
    chk("calc_in_ready", int'(in_ready), 0);
    drain();

    // single X1
    blk = '{0, 1000, 0, 0, 0, 0, 0, 0};
    load_block(1);
    drain();

    // overflow, both signs
    blk = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    load_block(1);
    drain();
    blk = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    load_block(0);
    drain();

    // backpressure at n=3
    rand_block();
    load_block(0);
    begin
      int g = 0;
      logic [DW-1:0] held;
      while (!(out_valid && out_idx == 3) && g < 200) begin
        @(posedge clk); #2;
        g++;
      end
      chk("bp_reach_n3", out_idx, 3);
      hold = 1; out_ready = 1'b0;
      held = out_data;
      repeat (10) begin
        @(negedge clk);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), int'(held));
        chk("bp_last", int'(out_last), 0);
        chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1; hold = 0;
    end
    drain();

    // in_valid during CALC must be ignored
    rand_block();
    load_block(1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom_range(0, 4095));
      @(negedge clk);
      chk("calc_ignore_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // reset during CALC, then a clean block
    rand_block();
    push_en = 0;
    load_block(0);
    push_en = 1;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", int'(in_ready), 1);
    chk("postrst_out_valid", int'(out_valid), 0);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_state", int'(state_dbg), 0);
    @(posedge clk); #1;
    rand_block();
    load_block(1);
    drain();

    // back-to-back random blocks with random handshakes
    rdy_rand = 1;
    for (int b = 0; b < 6; b++) begin
      rand_block();
      load_block(1);
      drain();
    end
    rdy_rand = 0;

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
